jstk_spi_responder: RTL and testbench

- SPI mode-0 slave that emulates the joystick peripheral on the far end of the joystick SPI link.
- Receives the 5-byte command frame from the joystick SPI master and returns 5 bytes of X/Y position and buttons.
- Decodes the two LED bits from the command byte.
- Used as a bench/board stand-in for the physical joystick and for a second-board paddle link. Runs on the system clock and oversamples sck/cs/mosi.

---
 rtl/jstk_spi_responder.sv | 118 +++++++++++
 tb/tb_jstk_spi_responder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/jstk_spi_responder.sv
// rtl/jstk_spi_responder.sv - SPI mode-0 joystick emulator: returns X/Y/buttons, decodes LED command
module jstk_spi_responder #(
  parameter int         FRAME_BYTES = 5,
  parameter logic [5:0] CMD_PREFIX  = 6'b100000,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk50M,
  input  logic       reset,
  input  logic       cs,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [2:0] btn,
  output logic [1:0] led,
  output logic       frame_done,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [5:0] LAST_BIT = 6'(8 * FRAME_BYTES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic sck_d, cs_d;
  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall, cs_rise, cs_fall;

  logic [39:0] tx, rx;
  logic [5:0]  bit_cnt;
  logic        load, rx_shift, tx_shift, miso_clr, led_we;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_rise  = cs_s & ~cs_d;
  assign cs_fall  = ~cs_s & cs_d;

  // cs history resets low so a cs held low across reset cannot look like a fall
  always_ff @(posedge clk50M) begin
    if (reset) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
    end
  end

  always_ff @(posedge clk50M) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cs_fall) next_state = SHIFT;
      SHIFT: begin
        if (cs_rise)                                next_state = IDLE;
        else if (sck_rise && bit_cnt == LAST_BIT)   next_state = DONE;
      end
      DONE:    if (cs_rise) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    load       = (state == IDLE) && cs_fall;
    rx_shift   = (state == SHIFT) && sck_rise && !cs_rise;
    tx_shift   = (state == SHIFT) && sck_fall && !cs_rise;
    miso_clr   = (state == SHIFT) && (next_state != SHIFT);
    frame_err  = (state == SHIFT) && cs_rise;
    frame_done = (state == DONE) && cs_rise;
    led_we     = frame_done && (rx[39:34] == CMD_PREFIX);
  end

  // tx holds the bits not yet on miso; miso itself is the current bit
  always_ff @(posedge clk50M) begin
    if (reset) begin
      tx      <= '0;
      rx      <= '0;
      bit_cnt <= '0;
      miso    <= 1'b0;
      led     <= 2'b00;
    end else begin
      if (load) begin
        miso    <= x[7];
        tx      <= {x[6:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 5'b0, btn, 1'b0};
        bit_cnt <= '0;
      end
      if (rx_shift) begin
        rx      <= {rx[38:0], mosi_s};
        bit_cnt <= bit_cnt + 6'd1;
      end
      if (tx_shift) begin
        miso <= tx[39];
        tx   <= {tx[38:0], 1'b0};
      end
      if (miso_clr) miso <= 1'b0;
      if (led_we)   led  <= rx[33:32];
    end
  end

endmodule

// File: tb/tb_jstk_spi_responder.sv
// tb/tb_jstk_spi_responder.sv - self-checking bench for jstk_spi_responder
module tb_jstk_spi_responder;

  logic       clk50M = 1'b0;
  logic       reset, cs, sck, mosi;
  logic       miso;
  logic [9:0] x, y;
  logic [2:0] btn;
  logic [1:0] led;
  logic       frame_done, frame_err, busy;

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  int n_err  = 0;

  jstk_spi_responder dut (
    .clk50M(clk50M), .reset(reset), .cs(cs), .sck(sck), .mosi(mosi), .miso(miso),
    .x(x), .y(y), .btn(btn), .led(led),
    .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
  );

  always #10 clk50M = ~clk50M;

  always @(negedge clk50M) begin
    if (frame_done) n_done++;
    if (frame_err)  n_err++;
  end

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [2:0]  btn;
    logic [7:0]  cmd;
    int          nbits;
    int          half;
    bit          snap;
    logic [39:0] exp_miso;
    logic [1:0]  exp_led;
    int          exp_done;
    int          exp_err;
  } vec_t;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk50M);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input logic [7:0] cmd, input int nbits, input int half,
                           input bit snap, output logic [47:0] got);
    logic [7:0] c;
    c    = cmd;
    got  = '0;
    cs   = 1'b0;
    mosi = c[7];
    cyc(half);
    for (int i = 0; i < nbits; i++) begin
      if (snap && i == 8) x = 10'h000;
      got = {got[46:0], miso};
      if (i == 4) chk("busy_mid", 64'(busy), 64'd1);
      sck = 1'b1;
      cyc(half);
      sck  = 1'b0;
      c    = c << 1;
      mosi = (i < 7) ? c[7] : 1'b0;
      cyc(half);
    end
    cs = 1'b1;
    cyc(half + 4);
  endtask

  // Reference: the bit stream the master should see, byte by byte, zeros past the payload
  function automatic logic [47:0] model_bits(input logic [9:0] xx, input logic [9:0] yy,
                                             input logic [2:0] bb, input int nbits);
    int bytes [5];
    logic [47:0] r;
    int b;
    bytes = '{int'(xx) % 256, int'(xx) / 256, int'(yy) % 256, int'(yy) / 256, int'(bb)};
    r = '0;
    for (int i = 0; i < nbits; i++) begin
      b = (i < 40) ? ((bytes[i / 8] >> (7 - i % 8)) & 1) : 0;
      r = {r[46:0], b[0]};
    end
    return r;
  endfunction

  vec_t vecs [6];
  logic [47:0] got, e48, mask, exp_got;
  logic [1:0]  led_m;
  int d0, e0, sel, nb, hp;
  logic [7:0] cmd;

  initial begin
    vecs[0] = '{10'h2A5, 10'h13C, 3'b101, 8'h83, 40, 25, 1'b0, 40'hA5_02_3C_01_05, 2'b11, 1, 0};
    vecs[1] = '{10'h2A5, 10'h13C, 3'b101, 8'h83, 40, 25, 1'b1, 40'hA5_02_3C_01_05, 2'b11, 1, 0};
    vecs[2] = '{10'h2A5, 10'h13C, 3'b101, 8'h80, 12, 20, 1'b0, 40'hA5_02_3C_01_05, 2'b11, 0, 1};
    vecs[3] = '{10'h3FF, 10'h000, 3'b111, 8'h81, 40, 12, 1'b0, 40'hFF_03_00_00_07, 2'b01, 1, 0};
    vecs[4] = '{10'h2A5, 10'h13C, 3'b101, 8'h42, 40, 10, 1'b0, 40'hA5_02_3C_01_05, 2'b01, 1, 0};
    vecs[5] = '{10'h155, 10'h2AA, 3'b010, 8'h82, 48, 9,  1'b0, 40'h55_01_AA_02_02, 2'b10, 1, 0};

    reset = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
    x = '0; y = '0; btn = '0;
    cyc(4);
    chk("rst_miso", 64'(miso), 64'd0);
    chk("rst_led", 64'(led), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(frame_done), 64'd0);
    chk("rst_err", 64'(frame_err), 64'd0);
    reset = 1'b0;
    cyc(6);

    for (int v = 0; v < 6; v++) begin
      x = vecs[v].x; y = vecs[v].y; btn = vecs[v].btn;
      d0 = n_done; e0 = n_err;
      run_frame(vecs[v].cmd, vecs[v].nbits, vecs[v].half, vecs[v].snap, got);
      e48  = {vecs[v].exp_miso, 8'h00};
      mask = ~48'h0 << (48 - vecs[v].nbits);
      chk($sformatf("vec%0d_miso", v), 64'(got << (48 - vecs[v].nbits)), 64'(e48 & mask));
      chk($sformatf("vec%0d_led", v), 64'(led), 64'(vecs[v].exp_led));
      chk($sformatf("vec%0d_done", v), 64'(n_done - d0), 64'(vecs[v].exp_done));
      chk($sformatf("vec%0d_err", v), 64'(n_err - e0), 64'(vecs[v].exp_err));
      chk($sformatf("vec%0d_busy", v), 64'(busy), 64'd0);
      chk($sformatf("vec%0d_idle_miso", v), 64'(miso), 64'd0);
    end

    // Reset at bit 20 with cs held low, then keep clocking sck
    x = 10'h2A5; y = 10'h13C; btn = 3'b101;
    d0 = n_done; e0 = n_err;
    cs = 1'b0; mosi = 1'b1;
    cyc(12);
    for (int i = 0; i < 20; i++) begin
      sck = 1'b1; cyc(12); sck = 1'b0; cyc(12);
    end
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
    chk("mid_rst_miso", 64'(miso), 64'd0);
    chk("mid_rst_led", 64'(led), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 10; i++) begin
      sck = 1'b1; cyc(12); sck = 1'b0; cyc(12);
    end
    chk("mid_rst_still_idle", 64'(busy), 64'd0);
    chk("mid_rst_miso_idle", 64'(miso), 64'd0);
    cs = 1'b1;
    cyc(12);
    chk("mid_rst_no_err", 64'(n_err - e0), 64'd0);
    chk("mid_rst_no_done", 64'(n_done - d0), 64'd0);
    run_frame(8'h83, 40, 15, 1'b0, got);
    chk("post_rst_miso", 64'(got), 64'(model_bits(10'h2A5, 10'h13C, 3'b101, 40)));
    chk("post_rst_led", 64'(led), 64'd3);
    chk("post_rst_done", 64'(n_done - d0), 64'd1);
    led_m = 2'b11;

    for (int r = 0; r < 8; r++) begin
      x   = 10'($urandom);
      y   = 10'($urandom);
      btn = 3'($urandom);
      cmd = 8'($urandom);
      if ($urandom_range(0, 1) == 1) cmd[7:2] = 6'b100000;
      sel = $urandom_range(0, 2);
      nb  = (sel == 0) ? 40 : (sel == 1) ? $urandom_range(41, 48) : $urandom_range(5, 39);
      hp  = $urandom_range(9, 20);
      exp_got = model_bits(x, y, btn, nb);
      if (nb >= 40 && cmd[7:2] == 6'b100000) led_m = cmd[1:0];
      d0 = n_done; e0 = n_err;
      run_frame(cmd, nb, hp, 1'b0, got);
      chk($sformatf("rnd%0d_miso", r), 64'(got), 64'(exp_got));
      chk($sformatf("rnd%0d_led", r), 64'(led), 64'(led_m));
      chk($sformatf("rnd%0d_done", r), 64'(n_done - d0), 64'((nb >= 40) ? 1 : 0));
      chk($sformatf("rnd%0d_err", r), 64'(n_err - e0), 64'((nb < 40) ? 1 : 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
